// File: rtl/fetch_unit.sv
// Instruction-fetch stage: BTB-predicted PC sequencing, pipelined valid/ready memory port,
// and an in-order instruction queue toward ID. EX redirects flush and drop in-flight responses.
module fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_ADDR  = '0,
  parameter int              QUEUE_DEPTH = 4,
  parameter int              BTB_ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_target,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int BW = $clog2(BTB_ENTRIES);
  localparam int TW = XLEN - BW - 2;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [QW-1:0]   head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CW-1:0]   alloc_q, alloc_d, drop_q, drop_d;

  logic [XLEN-1:0]        q_pc_q    [QUEUE_DEPTH];
  logic [XLEN-1:0]        q_tgt_q   [QUEUE_DEPTH];
  logic [XLEN-1:0]        q_instr_q [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_pt_q;
  logic [QUEUE_DEPTH-1:0] q_filled_q;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TW-1:0]          btb_tag_q [BTB_ENTRIES];
  logic [XLEN-1:0]        btb_tgt_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q [BTB_ENTRIES];

  // Lookup on the current PC
  logic [BW-1:0]   lk_idx;
  logic [TW-1:0]   lk_tag;
  logic            lk_hit, pred_taken;
  logic [XLEN-1:0] pred_next;

  assign lk_idx     = pc_q[BW+1:2];
  assign lk_tag     = pc_q[XLEN-1:BW+2];
  assign lk_hit     = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
  assign pred_taken = lk_hit && btb_ctr_q[lk_idx][1];
  assign pred_next  = pred_taken ? btb_tgt_q[lk_idx] : pc_q + XLEN'(4);

  logic [CW:0] occupancy;
  logic        has_room, req_fire, out_fire, resp_drop, resp_fill;

  assign occupancy     = (CW+1)'(alloc_q) + (CW+1)'(drop_q);
  assign has_room      = occupancy < (CW+1)'(QUEUE_DEPTH);
  // rst gates the request so the port reads idle while reset is held
  assign mem_req_valid = rst && !redir_valid && has_room;
  assign mem_req_addr  = pc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign out_valid       = q_filled_q[head_q] && !redir_valid;
  assign out_pc          = q_pc_q[head_q];
  assign out_instr       = q_instr_q[head_q];
  assign out_pred_taken  = q_pt_q[head_q];
  assign out_pred_target = q_tgt_q[head_q];
  assign out_fire        = out_valid && out_ready;

  assign resp_drop = mem_resp_valid && (drop_q != '0);
  assign resp_fill = mem_resp_valid && (drop_q == '0);

  // Responses still owed for allocated-but-unfilled entries become drops on redirect
  logic [CW-1:0] filled_cnt, unfilled_cnt;
  logic [CW:0]   redir_tot, redir_drop;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      filled_cnt = filled_cnt + CW'(q_filled_q[i]);
    end
  end

  assign unfilled_cnt = alloc_q - filled_cnt;
  assign redir_tot    = (CW+1)'(unfilled_cnt) + (CW+1)'(drop_q);
  assign redir_drop   = (mem_resp_valid && (redir_tot != '0)) ? redir_tot - (CW+1)'(1) : redir_tot;

  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    fill_d  = fill_q;
    tail_d  = tail_q;
    alloc_d = alloc_q;
    drop_d  = drop_q;
    if (redir_valid) begin
      pc_d    = redir_pc;
      head_d  = '0;
      fill_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      drop_d  = CW'(redir_drop);
    end else begin
      if (req_fire) begin
        pc_d   = pred_next;
        tail_d = tail_q + QW'(1);
      end
      if (resp_drop) drop_d = drop_q - CW'(1);
      if (resp_fill) fill_d = fill_q + QW'(1);
      if (out_fire)  head_d = head_q + QW'(1);
      case ({req_fire, out_fire})
        2'b10:   alloc_d = alloc_q + CW'(1);
        2'b01:   alloc_d = alloc_q - CW'(1);
        default: alloc_d = alloc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_ADDR;
      head_q  <= '0;
      fill_q  <= '0;
      tail_q  <= '0;
      alloc_q <= '0;
      drop_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      fill_q  <= fill_d;
      tail_q  <= tail_d;
      alloc_q <= alloc_d;
      drop_q  <= drop_d;
    end
  end

  // Tail, fill and head never alias in a cycle where more than one of them writes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_q[i]    <= '0;
        q_tgt_q[i]   <= '0;
        q_instr_q[i] <= '0;
      end
      q_pt_q     <= '0;
      q_filled_q <= '0;
    end else if (redir_valid) begin
      q_filled_q <= '0;
    end else begin
      if (req_fire) begin
        q_pc_q[tail_q]  <= pc_q;
        q_pt_q[tail_q]  <= pred_taken;
        q_tgt_q[tail_q] <= pred_next;
      end
      if (resp_fill) begin
        q_instr_q[fill_q]  <= mem_resp_data;
        q_filled_q[fill_q] <= 1'b1;
      end
      if (out_fire) begin
        q_pc_q[head_q]     <= '0;
        q_pt_q[head_q]     <= 1'b0;
        q_tgt_q[head_q]    <= '0;
        q_instr_q[head_q]  <= '0;
        q_filled_q[head_q] <= 1'b0;
      end
    end
  end

  // Training; branches are word-aligned, so a misaligned update address is ignored
  logic [BW-1:0] upd_idx;
  logic [TW-1:0] upd_tag;
  logic          upd_aligned, upd_hit;

  assign upd_idx     = upd_pc[BW+1:2];
  assign upd_tag     = upd_pc[XLEN-1:BW+2];
  assign upd_aligned = (upd_pc[1:0] == 2'b00);
  assign upd_hit     = btb_valid_q[upd_idx] && (btb_tag_q[upd_idx] == upd_tag);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        btb_ctr_q[i] <= 2'b01;
      end
    end else if (upd_valid && upd_aligned) begin
      if (upd_hit) begin
        if (upd_taken) begin
          btb_tgt_q[upd_idx] <= upd_target;
          if (btb_ctr_q[upd_idx] != 2'b11) btb_ctr_q[upd_idx] <= btb_ctr_q[upd_idx] + 2'b01;
        end else if (btb_ctr_q[upd_idx] != 2'b00) begin
          btb_ctr_q[upd_idx] <= btb_ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        btb_valid_q[upd_idx] <= 1'b1;
        btb_tag_q[upd_idx]   <= upd_tag;
        btb_tgt_q[upd_idx]   <= upd_target;
        btb_ctr_q[upd_idx]   <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases plus a randomized stretch, with an in-order
// memory model, a behavioural program/BTB model and a scoreboard checked at the ID port.
module tb_fetch_unit;
  localparam int XLEN = 32;
  localparam int QD   = 4;
  localparam int BTB  = 16;
  localparam int BW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            mem_req_valid, mem_req_ready = 1'b0;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_resp_valid = 1'b0;
  logic [XLEN-1:0] mem_resp_data = '0;
  logic            out_valid, out_ready = 1'b0;
  logic [XLEN-1:0] out_pc, out_instr, out_pred_target;
  logic            out_pred_taken;
  logic            redir_valid = 1'b0;
  logic [XLEN-1:0] redir_pc = '0;
  logic            upd_valid = 1'b0;
  logic [XLEN-1:0] upd_pc = '0, upd_target = '0;
  logic            upd_taken = 1'b0;

  fetch_unit #(.XLEN(XLEN), .RESET_ADDR(32'h0), .QUEUE_DEPTH(QD), .BTB_ENTRIES(BTB)) dut (
    .clk(clk), .rst(rst),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_pred_taken(out_pred_taken), .out_pred_target(out_pred_target),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken)
  );

  always #5 clk = ~clk;

  typedef struct { logic [XLEN-1:0] pc, instr, tgt; logic pt; } exp_t;
  typedef struct { logic [XLEN-1:0] data; int due; } mem_t;

  exp_t            expq[$];
  mem_t            mq[$];
  logic [XLEN-1:0] out_log[$];
  exp_t            mon_e;

  int n_checks = 0, n_fail = 0, cyc = 0, n_req = 0, last_due = 0, n0;
  logic [XLEN-1:0] mpc = '0;
  logic            bv[BTB];
  logic [XLEN-1:0] btag[BTB], btgt[BTB];
  int              bctr[BTB];

  int p_ready = 0, p_oready = 0, p_redir = 0, p_upd = 0, lat_lo = 1, lat_hi = 1;
  bit redir_req = 0, upd_req = 0, upd_tk = 0, watch_arm = 0;
  logic [XLEN-1:0] redir_addr = '0, upd_a = '0, upd_t = '0;
  logic [XLEN-1:0] watch_pc = '1, watch_next = '0, first_pc;

  function automatic logic [XLEN-1:0] mem_word(logic [XLEN-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic btb_model_reset();
    for (int i = 0; i < BTB; i++) begin
      bv[i] = 1'b0; btag[i] = '0; btgt[i] = '0; bctr[i] = 1;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then observe what the next rising edge commits
  task automatic step();
    mem_t m;
    int idx, lat, due;
    logic [XLEN-1:0] tg, nxt;
    logic pt;
    @(negedge clk);
    cyc++;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      m = mq.pop_front();
      mem_resp_valid = 1'b1;
      mem_resp_data  = m.data;
    end
    mem_req_ready = ($urandom_range(1, 100) <= p_ready);
    out_ready     = ($urandom_range(1, 100) <= p_oready);
    redir_valid   = redir_req || ($urandom_range(1, 100) <= p_redir);
    redir_pc      = redir_req ? redir_addr : ($urandom_range(0, 63) << 2);
    redir_req     = 0;
    upd_valid     = upd_req || ($urandom_range(1, 100) <= p_upd);
    upd_pc        = upd_req ? upd_a : ($urandom_range(0, 31) << 2);
    upd_target    = upd_req ? upd_t : ($urandom_range(0, 63) << 2);
    upd_taken     = upd_req ? upd_tk : 1'($urandom_range(0, 1));
    upd_req       = 0;
    #1;
    if (redir_valid) begin
      chk("req_in_redirect", 32'(mem_req_valid), 32'h0);
      chk("out_in_redirect", 32'(out_valid), 32'h0);
      mpc = redir_pc;
      expq.delete();
    end else if (mem_req_valid && mem_req_ready) begin
      chk("req_addr", mem_req_addr, mpc);
      idx = int'((mpc >> 2) % BTB);
      pt  = bv[idx] && (btag[idx] == (mpc >> (BW + 2))) && (bctr[idx] >= 2);
      nxt = pt ? btgt[idx] : mpc + 32'd4;
      expq.push_back('{pc: mpc, instr: mem_word(mpc), tgt: nxt, pt: pt});
      lat = $urandom_range(lat_lo, lat_hi);
      due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = due;
      mq.push_back('{data: mem_word(mem_req_addr), due: due});
      n_req++;
      if (watch_arm) begin
        watch_next = mem_req_addr;
        watch_arm  = 0;
        watch_pc   = '1;
      end
      if (mem_req_addr == watch_pc) watch_arm = 1;
      mpc = nxt;
    end
    if (upd_valid) begin
      idx = int'((upd_pc >> 2) % BTB);
      tg  = upd_pc >> (BW + 2);
      if (bv[idx] && btag[idx] == tg) begin
        if (upd_taken) begin
          btgt[idx] = upd_target;
          if (bctr[idx] < 3) bctr[idx]++;
        end else if (bctr[idx] > 0) begin
          bctr[idx]--;
        end
      end else if (upd_taken) begin
        bv[idx] = 1'b1; btag[idx] = tg; btgt[idx] = upd_target; bctr[idx] = 2;
      end
    end
  endtask

  task automatic redirect(logic [XLEN-1:0] a);
    redir_req = 1; redir_addr = a;
    step();
  endtask

  task automatic train(logic [XLEN-1:0] a, logic [XLEN-1:0] t, bit tk);
    upd_req = 1; upd_a = a; upd_t = t; upd_tk = tk;
    step();
  endtask

  task automatic watch(logic [XLEN-1:0] a);
    watch_pc = a; watch_arm = 0; watch_next = 32'hDEAD_BEEF;
  endtask

  task automatic apply_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pred_target", out_pred_target, 32'h0);
    chk("rst_out_pred_taken", 32'(out_pred_taken), 32'h0);
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; out_ready = 1'b0;
    redir_valid = 1'b0; upd_valid = 1'b0;
    mq.delete(); expq.delete(); btb_model_reset();
    mpc = 32'h0; last_due = 0; watch_arm = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("first_req_valid", 32'(mem_req_valid), 32'h1);
    chk("first_req_addr", mem_req_addr, 32'h0);
  endtask

  // Scoreboard monitor: pops one expectation per accepted instruction at the ID port
  always begin
    @(negedge clk);
    #2;
    if (rst && out_valid && out_ready) begin
      out_log.push_back(out_pc);
      if (expq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got pc %h, nothing expected", out_pc);
      end else begin
        mon_e = expq.pop_front();
        chk("out_pc", out_pc, mon_e.pc);
        chk("out_instr", out_instr, mon_e.instr);
        chk("out_pred_taken", 32'(out_pred_taken), 32'(mon_e.pt));
        chk("out_pred_target", out_pred_target, mon_e.tgt);
      end
    end
  end

  initial begin
    btb_model_reset();
    apply_reset();

    // Straight-line fetch, single-cycle memory
    p_ready = 100; p_oready = 100; lat_lo = 1; lat_hi = 1;
    out_log.delete();
    repeat (24) step();
    chk("straight_throughput", 32'(out_log.size() >= 20), 32'h1);

    // Queue fills with ID stalled, then one request per dequeue
    p_oready = 0;
    redirect(32'h200);
    n0 = n_req;
    repeat (12) step();
    chk("full_req_count", 32'(n_req - n0), 32'd4);
    chk("full_req_valid_low", 32'(mem_req_valid), 32'h0);
    p_oready = 100; n0 = n_req;
    step();
    chk("no_req_in_deq_cycle", 32'(n_req - n0), 32'd0);
    p_oready = 0;
    step();
    chk("req_after_deq", 32'(n_req - n0), 32'd1);
    step();
    chk("one_req_per_deq", 32'(n_req - n0), 32'd1);

    // Redirect with three slow responses outstanding
    p_ready = 0; p_oready = 100; lat_lo = 5; lat_hi = 5;
    redirect(32'h300);
    repeat (8) step();
    p_ready = 100; n0 = n_req;
    repeat (3) step();
    chk("three_outstanding", 32'(n_req - n0), 32'd3);
    p_ready = 0;
    out_log.delete();
    redirect(32'h100);
    p_ready = 100;
    repeat (30) step();
    first_pc = (out_log.size() > 0) ? out_log[0] : 32'hDEAD_BEEF;
    chk("redir_first_pc", first_pc, 32'h100);

    // BTB training and untraining at 0x8
    p_ready = 0; lat_lo = 1; lat_hi = 1;
    train(32'h8, 32'h40, 1'b1);
    train(32'h8, 32'h40, 1'b1);
    watch(32'h8);
    p_ready = 100;
    redirect(32'h0);
    repeat (12) step();
    chk("btb_taken_next", watch_next, 32'h40);
    p_ready = 0;
    train(32'h8, 32'h40, 1'b0);
    train(32'h8, 32'h40, 1'b0);
    watch(32'h8);
    p_ready = 100;
    redirect(32'h0);
    repeat (12) step();
    chk("btb_untrained_next", watch_next, 32'hC);

    // PC wraps past the top of the address space
    watch(32'hFFFF_FFFC);
    redirect(32'hFFFF_FFFC);
    repeat (8) step();
    chk("pc_wrap", watch_next, 32'h0);

    // Randomized traffic
    p_ready = 70; p_oready = 70; lat_lo = 1; lat_hi = 4; p_redir = 3; p_upd = 10;
    repeat (1500) step();
    p_redir = 0; p_upd = 0; p_ready = 0; p_oready = 100;
    repeat (30) step();
    chk("drain_empty", 32'(expq.size()), 32'd0);

    // Reset mid-stream with the queue full and the BTB trained
    lat_lo = 1; lat_hi = 1;
    train(32'h8, 32'h80, 1'b1);
    train(32'h8, 32'h80, 1'b1);
    p_ready = 100; p_oready = 0;
    redirect(32'h0);
    repeat (10) step();
    chk("full_before_reset", 32'(mem_req_valid), 32'h0);
    apply_reset();
    watch(32'h8);
    p_ready = 100; p_oready = 100;
    repeat (16) step();
    chk("btb_cleared_by_reset", watch_next, 32'hC);
    p_ready = 0;
    repeat (20) step();
    chk("final_drain", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
